// File: rtl/core_state_sequencer_pkg.sv
// Shared definitions for the scratch-core instruction-cycle sequencer.
// Holds the 3-bit state encoding and the stage-strobe indices. The frame
// write-enable controller uses the same stage indices.
package core_state_sequencer_pkg;

  // Instruction-cycle states, 3-bit encoding.
  typedef enum logic [2:0] {
    SEQ_IDLE       = 3'd0,
    SEQ_FETCH_REQ  = 3'd1,
    SEQ_FETCH_RECV = 3'd2,
    SEQ_DECODE     = 3'd3,
    SEQ_SETUP      = 3'd4,
    SEQ_EXECUTE    = 3'd5,
    SEQ_WRITEBACK  = 3'd6,
    SEQ_FAULT      = 3'd7
  } seqState_e;

  // Bit positions of the stage strobes in a packed stage vector.
  localparam int STAGE_FETCH_REQ  = 0;
  localparam int STAGE_FETCH_RECV = 1;
  localparam int STAGE_DECODE     = 2;
  localparam int STAGE_SETUP      = 3;
  localparam int STAGE_EXECUTE    = 4;
  localparam int STAGE_WRITEBACK  = 5;
  localparam int STAGE_COUNT      = 6;

  // True in states where the core is doing work on an instruction.
  function automatic logic isActiveState(input seqState_e st);
    return (st != SEQ_IDLE) && (st != SEQ_FAULT);
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter used for the sequencer performance counters.
// Ports:
//   clk   - clock
//   inc   - add one this cycle (ignored once the count is all-ones)
//   clr   - synchronous clear, wins over inc
//   count - current count (registered)
module seq_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Count register: clear, saturating increment, or hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/core_state_sequencer.sv
// Top-level instruction-cycle FSM for the scratch core. Walks each instruction
// through FETCH_REQ, FETCH_RECV, DECODE, SETUP, EXECUTE, WRITEBACK and emits a
// one-hot stage strobe per state. A fetch that never returns data traps the
// sequencer in FAULT until reset.
// Optional feature: define SEQ_PERF_COUNTERS_EN to build the retired and
// active-cycle counters; otherwise those ports are tied to zero.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   run, halt_request           - start permission, stop-after-retire request
//   mem_readReady/Valid         - instruction memory handshake inputs
//   exec_busy                   - execute unit still working
//   mem_readRequest             - read request to instruction memory
//   fetch_RequestState .. writebackState - one-hot stage strobes
//   halted, fault               - IDLE / FAULT indicators
//   retired_count, cycle_count  - performance counters
import core_state_sequencer_pkg::*;

module core_state_sequencer #(
  parameter int FETCH_TIMEOUT = 255,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     halt_request,
  input  logic                     mem_readReady,
  input  logic                     mem_readValid,
  input  logic                     exec_busy,
  output logic                     mem_readRequest,
  output logic                     fetch_RequestState,
  output logic                     fetch_ReceiveState,
  output logic                     decodeState,
  output logic                     setupState,
  output logic                     executeState,
  output logic                     writebackState,
  output logic                     halted,
  output logic                     fault,
  output logic [COUNTER_WIDTH-1:0] retired_count,
  output logic [COUNTER_WIDTH-1:0] cycle_count
);

  // Last counter value that still permits waiting; reaching it without
  // valid data means FETCH_TIMEOUT receive cycles have elapsed.
  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  seqState_e  state_r;
  seqState_e  nextState_s;
  logic [7:0] timeoutCnt_r;
  logic [7:0] timeoutCntNext_s;

  // State and fetch-timeout registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= SEQ_IDLE;
      timeoutCnt_r <= 8'd0;
    end else begin
      state_r      <= nextState_s;
      timeoutCnt_r <= timeoutCntNext_s;
    end
  end

  // Next-state logic and strobe decode from the current state.
  always_comb begin
    nextState_s        = state_r;
    timeoutCntNext_s   = timeoutCnt_r;
    fetch_RequestState = 1'b0;
    fetch_ReceiveState = 1'b0;
    decodeState        = 1'b0;
    setupState         = 1'b0;
    executeState       = 1'b0;
    writebackState     = 1'b0;
    halted             = 1'b0;
    fault              = 1'b0;
    case (state_r)
      SEQ_IDLE: begin
        halted = 1'b1;
        if (run) begin
          nextState_s = SEQ_FETCH_REQ;
        end else begin
          nextState_s = SEQ_IDLE;
        end
      end
      SEQ_FETCH_REQ: begin
        fetch_RequestState = 1'b1;
        // Valid data arriving alongside ready is not ours yet; only ready matters here.
        if (mem_readReady) begin
          nextState_s      = SEQ_FETCH_RECV;
          timeoutCntNext_s = 8'd0;
        end else begin
          nextState_s = SEQ_FETCH_REQ;
        end
      end
      SEQ_FETCH_RECV: begin
        fetch_ReceiveState = 1'b1;
        // Valid data beats the timeout when both land on the same cycle.
        if (mem_readValid) begin
          nextState_s = SEQ_DECODE;
        end else if (timeoutCnt_r == TIMEOUT_LAST) begin
          nextState_s = SEQ_FAULT;
        end else begin
          timeoutCntNext_s = timeoutCnt_r + 8'd1;
        end
      end
      SEQ_DECODE: begin
        decodeState = 1'b1;
        nextState_s = SEQ_SETUP;
      end
      SEQ_SETUP: begin
        setupState  = 1'b1;
        nextState_s = SEQ_EXECUTE;
      end
      SEQ_EXECUTE: begin
        executeState = 1'b1;
        if (exec_busy) begin
          nextState_s = SEQ_EXECUTE;
        end else begin
          nextState_s = SEQ_WRITEBACK;
        end
      end
      SEQ_WRITEBACK: begin
        writebackState = 1'b1;
        // Halt is only looked at here so a fetched instruction always retires.
        if (run && !halt_request) begin
          nextState_s = SEQ_FETCH_REQ;
        end else begin
          nextState_s = SEQ_IDLE;
        end
      end
      SEQ_FAULT: begin
        fault       = 1'b1;
        nextState_s = SEQ_FAULT;
      end
      default: begin
        fault       = 1'b1;
        nextState_s = SEQ_FAULT;
      end
    endcase
  end

  assign mem_readRequest = fetch_RequestState;

`ifdef SEQ_PERF_COUNTERS_EN
  seq_sat_counter #(.WIDTH(COUNTER_WIDTH)) uRetiredCounter (
    .clk   (clk),
    .inc   (writebackState),
    .clr   (reset),
    .count (retired_count)
  );

  seq_sat_counter #(.WIDTH(COUNTER_WIDTH)) uCycleCounter (
    .clk   (clk),
    .inc   (isActiveState(state_r)),
    .clr   (reset),
    .count (cycle_count)
  );
`else
  assign retired_count = '0;
  assign cycle_count   = '0;
`endif

endmodule

// File: tb/tb_core_state_sequencer.sv
module tb_core_state_sequencer;

  localparam int TO = 4;
  localparam int CW = 32;

  // Bench-side stage labels (independent of the design's encoding).
  localparam int M_IDLE = 10, M_REQ = 11, M_RECV = 12, M_DEC = 13;
  localparam int M_SETUP = 14, M_EXEC = 15, M_WB = 16, M_FAULT = 17;

  logic clk = 1'b0;
  logic reset, run, halt_request, mem_readReady, mem_readValid, exec_busy;
  logic mem_readRequest, fetch_RequestState, fetch_ReceiveState, decodeState;
  logic setupState, executeState, writebackState, halted, fault;
  logic [CW-1:0] retired_count, cycle_count;

  always #5 clk = ~clk;

  core_state_sequencer #(.FETCH_TIMEOUT(TO), .COUNTER_WIDTH(CW)) dut (
    .clk                (clk),
    .reset              (reset),
    .run                (run),
    .halt_request       (halt_request),
    .mem_readReady      (mem_readReady),
    .mem_readValid      (mem_readValid),
    .exec_busy          (exec_busy),
    .mem_readRequest    (mem_readRequest),
    .fetch_RequestState (fetch_RequestState),
    .fetch_ReceiveState (fetch_ReceiveState),
    .decodeState        (decodeState),
    .setupState         (setupState),
    .executeState       (executeState),
    .writebackState     (writebackState),
    .halted             (halted),
    .fault              (fault),
    .retired_count      (retired_count),
    .cycle_count        (cycle_count)
  );

  // Reference model state
  int            mStage  = M_IDLE;
  int            mWaited = 0;
  logic [CW-1:0] mRet    = '0;
  logic [CW-1:0] mCyc    = '0;

  logic [8:0]    expVecQ[$];
  logic [CW-1:0] expRetQ[$];
  logic [CW-1:0] expCycQ[$];

  int checks = 0;
  int fails  = 0;
  int cycleNo = 0;

  // Expected output vector {fault,halted,wb,ex,setup,dec,recv,req,memReq}
  function automatic logic [8:0] expVec(input int st);
    logic [8:0] v;
    v    = 9'd0;
    v[8] = (st == M_FAULT);
    v[7] = (st == M_IDLE);
    v[6] = (st == M_WB);
    v[5] = (st == M_EXEC);
    v[4] = (st == M_SETUP);
    v[3] = (st == M_DEC);
    v[2] = (st == M_RECV);
    v[1] = (st == M_REQ);
    v[0] = (st == M_REQ);
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expectation.
  task automatic apply(input bit r, input bit ru, input bit h, input bit rd, input bit v, input bit b);
    reset = r; run = ru; halt_request = h;
    mem_readReady = rd; mem_readValid = v; exec_busy = b;
    if (r) begin
      mStage = M_IDLE; mWaited = 0; mRet = '0; mCyc = '0;
    end else begin
      if (mStage != M_IDLE && mStage != M_FAULT && mCyc != '1) mCyc = mCyc + CW'(1);
      if (mStage == M_WB && mRet != '1) mRet = mRet + CW'(1);
      case (mStage)
        M_IDLE:  if (ru) mStage = M_REQ;
        M_REQ:   if (rd) begin mStage = M_RECV; mWaited = 0; end
        M_RECV:  if (v) mStage = M_DEC;
                 else begin
                   mWaited++;
                   if (mWaited >= TO) mStage = M_FAULT;
                 end
        M_DEC:   mStage = M_SETUP;
        M_SETUP: mStage = M_EXEC;
        M_EXEC:  if (!b) mStage = M_WB;
        M_WB:    mStage = (ru && !h) ? M_REQ : M_IDLE;
        default: mStage = M_FAULT;
      endcase
    end
    expVecQ.push_back(expVec(mStage));
`ifdef SEQ_PERF_COUNTERS_EN
    expRetQ.push_back(mRet);
    expCycQ.push_back(mCyc);
`else
    expRetQ.push_back('0);
    expCycQ.push_back('0);
`endif
  endtask

  task automatic step(input bit r, input bit ru, input bit h, input bit rd, input bit v, input bit b);
    @(negedge clk);
    apply(r, ru, h, rd, v, b);
  endtask

  // Monitor: pop one expectation per clock and compare.
  initial begin
    logic [8:0]    ev, av;
    logic [CW-1:0] er, ec;
    forever begin
      @(posedge clk);
      #1;
      cycleNo++;
      av = {fault, halted, writebackState, executeState, setupState, decodeState,
            fetch_ReceiveState, fetch_RequestState, mem_readRequest};
      checks++;
      if (expVecQ.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty cycle %0d: got outputs %b, no expectation queued", cycleNo, av);
      end else begin
        ev = expVecQ.pop_front();
        er = expRetQ.pop_front();
        ec = expCycQ.pop_front();
        if (av !== ev) begin
          fails++;
          $display("FAIL stage_vec cycle %0d: got %b want %b", cycleNo, av, ev);
        end
        checks++;
        if (retired_count !== er) begin
          fails++;
          $display("FAIL retired_count cycle %0d: got %0d want %0d", cycleNo, retired_count, er);
        end
        checks++;
        if (cycle_count !== ec) begin
          fails++;
          $display("FAIL cycle_count cycle %0d: got %0d want %0d", cycleNo, cycle_count, ec);
        end
      end
      checks++;
      if ($countones({fetch_RequestState, fetch_ReceiveState, decodeState,
                      setupState, executeState, writebackState}) > 1) begin
        fails++;
        $display("FAIL onehot cycle %0d: got %b want at most one strobe", cycleNo, av);
      end
    end
  end

  // Stimulus
  initial begin
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Zero-wait back-to-back instructions, valid high together with ready
    repeat (14) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    // Busy execute: hold busy for a stretch
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    // Halt pulse early in an instruction, then halt held through writeback
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    // Fetch timeout: valid never arrives
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (9) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Valid on the last permitted receive cycle
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    // Three instructions then halt at the third writeback; reset mid-execute
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (18) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(63) == 0,
           $urandom_range(7) != 0,
           $urandom_range(5) == 0,
           $urandom_range(3) != 0,
           $urandom_range(2) == 0,
           $urandom_range(1) == 0);
    end
    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
